// File: rtl/sincos_arbiter.sv
// sincos_arbiter
//
// Shares one sincos pipeline between two angle requesters:
//   A = forward Park transform, B = inverse Park / SVPWM path.
// Requests are granted round-robin (or fixed priority, see below), each
// issued request leaves a 1-bit tag (0 = A, 1 = B) in an in-order tag FIFO,
// and every sincos result is routed back to the requester named by the
// oldest tag.
//
// Handshake: a requester raises x_req with x_theta and holds both until
// x_ack is seen high. x_ack is combinational; the transfer happens at the
// rising clk edge where x_req and x_ack are both high, and a new angle may be
// presented in the very next cycle.
//
// Configuration macro:
//   SINCOS_ARB_FIXED_PRIO_EN  defined   -> A always wins a tie (B may starve)
//                             undefined -> round-robin on ties (default)
//
// Parameters:
//   DEPTH    max outstanding requests / tag FIFO depth (2..16); use at least
//            sincos latency + 1 for one grant per cycle.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   a_req, a_theta            requester A angle request (12-bit angle)
//   a_ack                     combinational accept for A
//   a_en, a_sin, a_cos        one-cycle result strobe and result for A
//   b_*                       same set for requester B
//   s_en, s_theta             request into sincos (i_en / i_theta)
//   s_oen, s_sin, s_cos       result from sincos (o_en / o_sin / o_cos)
//   busy                      at least one request outstanding
//   err                       sticky: a result arrived with no tag pending

module sincos_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,

    input  logic               a_req,
    input  logic [11:0]        a_theta,
    output logic               a_ack,
    output logic               a_en,
    output logic signed [15:0] a_sin,
    output logic signed [15:0] a_cos,

    input  logic               b_req,
    input  logic [11:0]        b_theta,
    output logic               b_ack,
    output logic               b_en,
    output logic signed [15:0] b_sin,
    output logic signed [15:0] b_cos,

    output logic               s_en,
    output logic [11:0]        s_theta,
    input  logic               s_oen,
    input  logic signed [15:0] s_sin,
    input  logic signed [15:0] s_cos,

    output logic               busy,
    output logic               err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]   tag_q;

    logic               s_en_q;
    logic [11:0]        s_theta_q;
    logic               a_en_q, b_en_q;
    logic signed [15:0] a_sin_q, a_cos_q, b_sin_q, b_cos_q;
    logic               err_q;

    logic fifo_empty;
    logic pop;
    logic pop_tag;
    logic can_grant;
    logic grant_a, grant_b;
    logic push;

    assign fifo_empty = (cnt_q == '0);
    assign pop        = s_oen & ~fifo_empty;
    assign pop_tag    = tag_q[rd_ptr_q];

    // A full FIFO can still take a request when a result pops in the same
    // cycle, so the slot being freed is reused immediately.
    assign can_grant  = (cnt_q < DEPTH_C) | ((cnt_q == DEPTH_C) & s_oen);

`ifdef SINCOS_ARB_FIXED_PRIO_EN
    // A always wins; no history needed.
    always_comb begin
        grant_a = can_grant & a_req;
        grant_b = can_grant & b_req & ~a_req;
    end
`else
    logic last_q, last_d;

    // On a tie, the side that was not granted last wins. last_q resets to B
    // so A wins the first tie.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (can_grant) begin
            if (a_req && b_req) begin
                if (last_q == SIDE_B) grant_a = 1'b1;
                else                  grant_b = 1'b1;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant_a)      last_d = SIDE_A;
        else if (grant_b) last_d = SIDE_B;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_q <= SIDE_B;
        else       last_q <= last_d;
    end
`endif

    assign push = grant_a | grant_b;

    // Acks are masked by rstn so nothing looks accepted while in reset.
    assign a_ack = rstn & grant_a;
    assign b_ack = rstn & grant_b;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) tag_q[wr_ptr_q] <= grant_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_en_q    <= 1'b0;
            s_theta_q <= '0;
            a_en_q    <= 1'b0;
            b_en_q    <= 1'b0;
            a_sin_q   <= '0;
            a_cos_q   <= '0;
            b_sin_q   <= '0;
            b_cos_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            s_en_q <= push;
            if (grant_a)      s_theta_q <= a_theta;
            else if (grant_b) s_theta_q <= b_theta;

            a_en_q <= pop & (pop_tag == SIDE_A);
            b_en_q <= pop & (pop_tag == SIDE_B);
            if (pop && pop_tag == SIDE_A) begin
                a_sin_q <= s_sin;
                a_cos_q <= s_cos;
            end
            if (pop && pop_tag == SIDE_B) begin
                b_sin_q <= s_sin;
                b_cos_q <= s_cos;
            end

            // A result with no tag pending has no owner: drop it and flag it.
            if (s_oen && fifo_empty) err_q <= 1'b1;
        end
    end

    assign s_en    = s_en_q;
    assign s_theta = s_theta_q;
    assign a_en    = a_en_q;
    assign a_sin   = a_sin_q;
    assign a_cos   = a_cos_q;
    assign b_en    = b_en_q;
    assign b_sin   = b_sin_q;
    assign b_cos   = b_cos_q;
    assign busy    = (cnt_q != '0);
    assign err     = err_q;

endmodule

// File: tb/tb_sincos_arbiter.sv
`timescale 1ns/1ps

module tb_sincos_arbiter;

    localparam int L1 = 3;   // stub latency for the DEPTH=4 instance
    localparam int L2 = 4;   // stub latency for the DEPTH=2 instance

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- sincos reference angles ----------------
    function automatic logic signed [15:0] ref_sin(input logic [11:0] t);
        case (t)
            12'd0:    return 16'sd0;
            12'd1024: return 16'sd16384;
            12'd2048: return 16'sd0;
            12'd3072: return -16'sd16384;
            default:  return $signed({4'b0000, t});
        endcase
    endfunction

    function automatic logic signed [15:0] ref_cos(input logic [11:0] t);
        case (t)
            12'd0:    return 16'sd16384;
            12'd1024: return 16'sd0;
            12'd2048: return -16'sd16384;
            12'd3072: return 16'sd0;
            default:  return -$signed({4'b0000, t});
        endcase
    endfunction

    // ---------------- DUT 1: DEPTH=4 ----------------
    logic               a_req, b_req, a_ack, b_ack, a_en, b_en;
    logic [11:0]        a_theta, b_theta;
    logic signed [15:0] a_sin, a_cos, b_sin, b_cos;
    logic               s_en, s_oen, busy, err, force_oen;
    logic [11:0]        s_theta;
    logic signed [15:0] s_sin, s_cos;

    sincos_arbiter #(.DEPTH(4)) u_dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_theta(a_theta), .a_ack(a_ack), .a_en(a_en), .a_sin(a_sin), .a_cos(a_cos),
        .b_req(b_req), .b_theta(b_theta), .b_ack(b_ack), .b_en(b_en), .b_sin(b_sin), .b_cos(b_cos),
        .s_en(s_en), .s_theta(s_theta), .s_oen(s_oen), .s_sin(s_sin), .s_cos(s_cos),
        .busy(busy), .err(err)
    );

    logic [L1-1:0] p1_v;
    logic [11:0]   p1_t [L1];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1_v <= '0;
            for (int i = 0; i < L1; i++) p1_t[i] <= '0;
        end else begin
            p1_v    <= {p1_v[L1-2:0], s_en};
            p1_t[0] <= s_theta;
            for (int i = 1; i < L1; i++) p1_t[i] <= p1_t[i-1];
        end
    end
    assign s_oen = p1_v[L1-1] | force_oen;
    assign s_sin = ref_sin(p1_t[L1-1]);
    assign s_cos = ref_cos(p1_t[L1-1]);

    // ---------------- DUT 2: DEPTH=2 ----------------
    logic               d2_a_req, d2_b_req, d2_a_ack, d2_b_ack, d2_a_en, d2_b_en;
    logic [11:0]        d2_a_theta, d2_b_theta;
    logic signed [15:0] d2_a_sin, d2_a_cos, d2_b_sin, d2_b_cos;
    logic               d2_s_en, d2_s_oen, d2_busy, d2_err;
    logic [11:0]        d2_s_theta;
    logic signed [15:0] d2_s_sin, d2_s_cos;

    sincos_arbiter #(.DEPTH(2)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .a_req(d2_a_req), .a_theta(d2_a_theta), .a_ack(d2_a_ack), .a_en(d2_a_en), .a_sin(d2_a_sin), .a_cos(d2_a_cos),
        .b_req(d2_b_req), .b_theta(d2_b_theta), .b_ack(d2_b_ack), .b_en(d2_b_en), .b_sin(d2_b_sin), .b_cos(d2_b_cos),
        .s_en(d2_s_en), .s_theta(d2_s_theta), .s_oen(d2_s_oen), .s_sin(d2_s_sin), .s_cos(d2_s_cos),
        .busy(d2_busy), .err(d2_err)
    );

    logic [L2-1:0] p2_v;
    logic [11:0]   p2_t [L2];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p2_v <= '0;
            for (int i = 0; i < L2; i++) p2_t[i] <= '0;
        end else begin
            p2_v    <= {p2_v[L2-2:0], d2_s_en};
            p2_t[0] <= d2_s_theta;
            for (int i = 1; i < L2; i++) p2_t[i] <= p2_t[i-1];
        end
    end
    assign d2_s_oen = p2_v[L2-1];
    assign d2_s_sin = ref_sin(p2_t[L2-1]);
    assign d2_s_cos = ref_cos(p2_t[L2-1]);

    // ---------------- driver tasks ----------------
    task automatic idle_inputs;
        a_req = 1'b0; b_req = 1'b0; a_theta = '0; b_theta = '0;
        d2_a_req = 1'b0; d2_b_req = 1'b0; d2_a_theta = '0; d2_b_theta = '0;
        force_oen = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        idle_inputs();
        rstn = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_theta = 12'd5; b_theta = 12'd6;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({a_ack, b_ack} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ack: got %b exp 00", {a_ack, b_ack});
        end
        n_checks++;
        if ({s_en, a_en, b_en, busy, err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 00000", {s_en, a_en, b_en, busy, err});
        end
        n_checks++;
        if (s_theta !== 12'd0) begin
            n_fail++; $display("FAIL reset_s_theta: got %0d exp 0", s_theta);
        end
        n_checks++;
        if ({a_sin, a_cos, b_sin, b_cos} !== 64'd0) begin
            n_fail++; $display("FAIL reset_data: got %h exp 0", {a_sin, a_cos, b_sin, b_cos});
        end
        n_checks++;
        if ({d2_busy, d2_err, d2_s_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_d2_flags: got %b exp 000", {d2_busy, d2_err, d2_s_en});
        end
        idle_inputs();
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_a;
        int a_cnt, b_cnt, a_at;
        logic signed [15:0] sg, cg;
        a_cnt = 0; b_cnt = 0; a_at = -1; sg = '0; cg = '0;
        do_reset();
        a_req = 1'b1; a_theta = 12'd0;
        #1;
        n_checks++;
        if (a_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b exp 1", a_ack); end
        @(negedge clk);
        a_req = 1'b0;
        n_checks++;
        if ({s_en, busy, s_theta} !== {2'b11, 12'd0}) begin
            n_fail++; $display("FAIL single_issue: got s_en=%b busy=%b theta=%0d exp 1 1 0", s_en, busy, s_theta);
        end
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (a_en) begin a_cnt++; a_at = i; sg = a_sin; cg = a_cos; end
            if (b_en) b_cnt++;
        end
        n_checks++;
        if (a_cnt !== 1 || a_at !== L1 + 2) begin
            n_fail++; $display("FAIL single_latency: got pulses=%0d at=%0d exp 1 at %0d", a_cnt, a_at, L1 + 2);
        end
        n_checks++;
        if (sg !== 16'sd0 || cg !== 16'sd16384) begin
            n_fail++; $display("FAIL single_data: got sin=%0d cos=%0d exp 0 16384", sg, cg);
        end
        n_checks++;
        if (b_cnt !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got b_pulses=%0d busy=%b exp 0 0", b_cnt, busy);
        end
    endtask

    task automatic test_simultaneous;
        int a_at, b_at, a_cnt, b_cnt;
        logic signed [15:0] as_g, ac_g, bs_g, bc_g;
        a_at = -1; b_at = -1; a_cnt = 0; b_cnt = 0;
        as_g = '0; ac_g = '0; bs_g = '0; bc_g = '0;
        do_reset();
        a_req = 1'b1; a_theta = 12'd1024; b_req = 1'b1; b_theta = 12'd2048;
        #1;
        n_checks++;
        if ({a_ack, b_ack} !== 2'b10) begin n_fail++; $display("FAIL simul_first: got %b exp 10", {a_ack, b_ack}); end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        n_checks++;
        if ({a_ack, b_ack} !== 2'b01) begin n_fail++; $display("FAIL simul_second: got %b exp 01", {a_ack, b_ack}); end
        @(negedge clk);
        b_req = 1'b0;
        for (int i = 3; i <= 12; i++) begin
            @(negedge clk);
            if (a_en) begin a_cnt++; a_at = i; as_g = a_sin; ac_g = a_cos; end
            if (b_en) begin b_cnt++; b_at = i; bs_g = b_sin; bc_g = b_cos; end
        end
        n_checks++;
        if (a_cnt !== 1 || b_cnt !== 1 || a_at !== L1 + 2 || b_at !== L1 + 3) begin
            n_fail++; $display("FAIL simul_timing: got a=%0d@%0d b=%0d@%0d exp 1@%0d 1@%0d",
                               a_cnt, a_at, b_cnt, b_at, L1 + 2, L1 + 3);
        end
        n_checks++;
        if (as_g !== 16'sd16384 || ac_g !== 16'sd0) begin
            n_fail++; $display("FAIL simul_a_data: got %0d %0d exp 16384 0", as_g, ac_g);
        end
        n_checks++;
        if (bs_g !== 16'sd0 || bc_g !== -16'sd16384) begin
            n_fail++; $display("FAIL simul_b_data: got %0d %0d exp 0 -16384", bs_g, bc_g);
        end
    endtask

    task automatic test_round_robin;
        logic [32:0] exp_q[$];
        logic [32:0] got, expv;
        logic exp_a;
        int ka, kb, n_res;
        ka = 0; kb = 0; n_res = 0;
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (a_en || b_en) begin
                n_res++;
                got = {b_en, (a_en ? a_sin : b_sin), (a_en ? a_cos : b_cos)};
                n_checks++;
                if ((a_en && b_en) || exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rr_result_extra: got %h exp none", got);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        n_fail++; $display("FAIL rr_result: got %h exp %h", got, expv);
                    end
                end
            end
            if (cyc < 8) begin
                a_req = 1'b1; b_req = 1'b1;
                a_theta = 12'(100 + ka); b_theta = 12'(200 + kb);
            end else begin
                a_req = 1'b0; b_req = 1'b0;
            end
            #1;
            if (cyc < 8) begin
`ifdef SINCOS_ARB_FIXED_PRIO_EN
                exp_a = 1'b1;
`else
                exp_a = (cyc % 2 == 0);
`endif
                n_checks++;
                if ({a_ack, b_ack} !== {exp_a, ~exp_a}) begin
                    n_fail++; $display("FAIL rr_grant cyc=%0d: got %b exp %b", cyc, {a_ack, b_ack}, {exp_a, ~exp_a});
                end
                if (exp_a) exp_q.push_back({1'b0, ref_sin(a_theta), ref_cos(a_theta)});
                else       exp_q.push_back({1'b1, ref_sin(b_theta), ref_cos(b_theta)});
                if (a_ack) ka++;
                if (b_ack) kb++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0 || n_res !== 8) begin
            n_fail++; $display("FAIL rr_drain: got results=%0d pending=%0d exp 8 0", n_res, exp_q.size());
        end
`ifdef SINCOS_ARB_FIXED_PRIO_EN
        n_checks++;
        if (ka !== 8 || kb !== 0) begin n_fail++; $display("FAIL rr_counts: got a=%0d b=%0d exp 8 0", ka, kb); end
`else
        n_checks++;
        if (ka !== 4 || kb !== 4) begin n_fail++; $display("FAIL rr_counts: got a=%0d b=%0d exp 4 4", ka, kb); end
`endif
    endtask

    task automatic test_full_fifo;
        logic [32:0] exp_q[$];
        logic [32:0] got, expv;
        logic ea, eb, can, pop_m, last_m;
        int cnt_m, ka, kb, n_res, n_grant, grant_on_pop, stalls;
        cnt_m = 0; ka = 0; kb = 0; n_res = 0; n_grant = 0; grant_on_pop = 0; stalls = 0;
        last_m = 1'b1;
        do_reset();
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (d2_a_en || d2_b_en) begin
                n_res++;
                got = {d2_b_en, (d2_a_en ? d2_a_sin : d2_b_sin), (d2_a_en ? d2_a_cos : d2_b_cos)};
                n_checks++;
                if ((d2_a_en && d2_b_en) || exp_q.size() == 0) begin
                    n_fail++; $display("FAIL full_result_extra: got %h exp none", got);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        n_fail++; $display("FAIL full_result: got %h exp %h", got, expv);
                    end
                end
            end
            if (cyc < 30) begin
                d2_a_req = 1'b1; d2_b_req = 1'b1;
                d2_a_theta = 12'(300 + ka); d2_b_theta = 12'(400 + kb);
            end else begin
                d2_a_req = 1'b0; d2_b_req = 1'b0;
            end
            #1;
            pop_m = d2_s_oen && (cnt_m != 0);
            can   = (cnt_m < 2) || (cnt_m == 2 && d2_s_oen);
`ifdef SINCOS_ARB_FIXED_PRIO_EN
            ea = can && d2_a_req;
            eb = can && d2_b_req && !d2_a_req;
`else
            ea = can && d2_a_req && (!d2_b_req || last_m);
            eb = can && d2_b_req && (!d2_a_req || !last_m);
`endif
            n_checks++;
            if ({d2_a_ack, d2_b_ack} !== {ea, eb}) begin
                n_fail++; $display("FAIL full_grant cyc=%0d cnt=%0d: got %b exp %b", cyc, cnt_m, {d2_a_ack, d2_b_ack}, {ea, eb});
            end
            if (cnt_m == 2 && !d2_s_oen && d2_a_req) stalls++;
            if ((ea || eb) && cnt_m == 2) grant_on_pop++;
            if (ea) begin exp_q.push_back({1'b0, ref_sin(d2_a_theta), ref_cos(d2_a_theta)}); last_m = 1'b0; end
            if (eb) begin exp_q.push_back({1'b1, ref_sin(d2_b_theta), ref_cos(d2_b_theta)}); last_m = 1'b1; end
            if (ea || eb) n_grant++;
            cnt_m = cnt_m + ((ea || eb) ? 1 : 0) - (pop_m ? 1 : 0);
            if (d2_a_ack) ka++;
            if (d2_b_ack) kb++;
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0 || n_res !== n_grant || n_grant < 8) begin
            n_fail++; $display("FAIL full_drain: got results=%0d grants=%0d pending=%0d", n_res, n_grant, exp_q.size());
        end
        n_checks++;
        if (stalls == 0 || grant_on_pop == 0) begin
            n_fail++; $display("FAIL full_coverage: got stalls=%0d grant_on_pop=%0d exp both >0", stalls, grant_on_pop);
        end
        n_checks++;
        if ({d2_busy, d2_err} !== 2'b00) begin
            n_fail++; $display("FAIL full_end: got busy/err=%b exp 00", {d2_busy, d2_err});
        end
    endtask

    task automatic test_spurious;
        int a_cnt, x_cnt;
        a_cnt = 0; x_cnt = 0;
        do_reset();
        force_oen = 1'b1;
        @(negedge clk);
        force_oen = 1'b0;
        n_checks++;
        if ({err, a_en, b_en, busy} !== 4'b1000) begin
            n_fail++; $display("FAIL spur_set: got err/a_en/b_en/busy=%b exp 1000", {err, a_en, b_en, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({err, a_en, b_en} !== 3'b100) begin
            n_fail++; $display("FAIL spur_sticky: got err/a_en/b_en=%b exp 100", {err, a_en, b_en});
        end
        a_req = 1'b1; a_theta = 12'd2048;
        @(negedge clk);
        a_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_en) begin
                a_cnt++;
                if (a_cos !== -16'sd16384) x_cnt++;
            end
        end
        n_checks++;
        if (a_cnt !== 1 || x_cnt !== 0 || err !== 1'b1) begin
            n_fail++; $display("FAIL spur_after: got pulses=%0d bad=%0d err=%b exp 1 0 1", a_cnt, x_cnt, err);
        end
        do_reset();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL spur_clear: got %b exp 0", err); end
    endtask

    task automatic test_reset_midflight;
        int a_at, x_cnt;
        logic signed [15:0] sg, cg;
        a_at = -1; x_cnt = 0; sg = '0; cg = '0;
        do_reset();
        a_req = 1'b1; a_theta = 12'd1024;
        @(negedge clk);
        a_req = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (a_sin !== 16'sd16384) begin n_fail++; $display("FAIL mid_pre: got %0d exp 16384", a_sin); end
        a_req = 1'b1; a_theta = 12'd0;
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b1; b_theta = 12'd1024;
        @(negedge clk);
        b_req = 1'b0; a_req = 1'b1; a_theta = 12'd2048;
        @(negedge clk);
        n_checks++;
        if ({busy, s_en, s_theta} !== {2'b11, 12'd2048}) begin
            n_fail++; $display("FAIL mid_inflight: got busy=%b s_en=%b theta=%0d exp 1 1 2048", busy, s_en, s_theta);
        end
        #1;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({busy, s_en, a_en, b_en, err, a_ack, b_ack} !== 7'b0) begin
            n_fail++; $display("FAIL mid_reset_flags: got %b exp 0000000", {busy, s_en, a_en, b_en, err, a_ack, b_ack});
        end
        n_checks++;
        if ({s_theta, a_sin, a_cos, b_sin, b_cos} !== 76'd0) begin
            n_fail++; $display("FAIL mid_reset_data: got %h exp 0", {s_theta, a_sin, a_cos, b_sin, b_cos});
        end
        @(negedge clk);
        a_req = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_en || b_en) x_cnt++;
        end
        n_checks++;
        if (x_cnt !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_stale: got pulses=%0d busy=%b exp 0 0", x_cnt, busy);
        end
        a_req = 1'b1; a_theta = 12'd3072;
        @(negedge clk);
        a_req = 1'b0;
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk);
            if (a_en) begin a_at = i; sg = a_sin; cg = a_cos; end
        end
        n_checks++;
        if (a_at !== L1 + 2 || sg !== -16'sd16384 || cg !== 16'sd0) begin
            n_fail++; $display("FAIL mid_after: got at=%0d sin=%0d cos=%0d exp %0d -16384 0", a_at, sg, cg, L1 + 2);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_single_a();
        test_simultaneous();
        test_round_robin();
        test_full_fifo();
        test_spurious();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sincos_arbiter.md
# sincos_arbiter

Shares a single `sincos` pipeline between two independent angle requesters: port A is the forward Park transform and port B is the inverse Park / SVPWM path. Requests use a valid/ack handshake. Grants follow a round-robin order. Each issued request is tagged in an in-order tag FIFO, and each `sincos` result is routed back to the requester that issued it. The block sits between the angle sources and one `sincos` instance, so the FOC loop needs only one lookup table.

## Interface
- `DEPTH`, default 4: maximum number of outstanding requests (tag FIFO depth). Legal range is 2..16. It must be at least the `sincos` latency plus 1 for full throughput.
- `rstn`  in  1  reset; asynchronous, active-low.
- `clk`  in  1  single clock.
- `a_req`  in  1  requester A has a valid angle; held until acknowledged.
- `a_theta`  in  12  requester A angle: 0..4095 = 0..360°.
- `a_ack`  out  1  combinational; when high, `a_req` is accepted on this edge.
- `a_en`  out  1  one-cycle pulse: `a_sin`/`a_cos` are valid.
- `a_sin`, `a_cos`  out  16 signed  result for A; amplitude ±16384.
- `b_req`, `b_theta`, `b_ack`, `b_en`, `b_sin`, `b_cos`: same as the A ports, for requester B.
- `s_en`  out  1  drives `sincos.i_en`.
- `s_theta`  out  12  drives `sincos.i_theta`.
- `s_oen`  in  1  from `sincos.o_en`.
- `s_sin`, `s_cos`  in  16 signed  from `sincos.o_sin` and `sincos.o_cos`.
- `busy`  out  1  at least one request is outstanding (`cnt != 0`).
- `err`  out  1  sticky: a result arrived while the tag FIFO was empty.

## Operation
- **Grant condition:** grant is possible when `cnt < DEPTH`, or when `cnt == DEPTH` and `s_oen == 1` in the same cycle (simultaneous pop frees a slot).
- **Arbitration:**
  - If only one requester is active, it is granted.
  - If both are active, grant the one not granted last. `last` is a 1-bit register; it resets to B, so A wins the first tie.
  - At most one grant per cycle.
- **Acknowledge:** `a_ack = a_req & grantA`, and likewise for B. Acceptance happens at the clock edge where req and ack are both high. The requester may present a new angle on the next cycle, so back-to-back acceptance is allowed.
- **On grant, registered at the edge:**
  - `s_en <= 1`, `s_theta <=` the granted theta.
  - Push the tag (0 = A, 1 = B) into the FIFO.
  - `cnt += 1`, `last <=` granted side.
- **With no grant:** `s_en <= 0` and `s_theta` holds its value.
- **On `s_oen` with the FIFO non-empty:**
  - Pop the tag.
  - `cnt -= 1`, or no net change if a push happens in the same cycle.
  - Register `s_sin`/`s_cos` into the tagged side's outputs and pulse that side's `en` for one cycle. The other side's outputs hold.
- **On `s_oen` with the FIFO empty:** drop the result, set `err <= 1`, leave `cnt` unchanged.
  - `err` clears only on reset.
- **FIFO:** circular read/write pointers of width ceil(log2 DEPTH), wrapping modulo DEPTH. `cnt` is ceil(log2(DEPTH+1)) bits wide. Order is preserved because `sincos` is in-order.
- **Data integrity:** result data passes through bit-exact; no scaling or rounding.

## Timing
- **Reset values:** `s_en`=0, `s_theta`=0, `a_en`/`b_en`=0, all sin/cos outputs 0, `cnt`=0, FIFO pointers 0, `last`=B, `err`=0.
- `busy` = (`cnt != 0`), so it is 0 while in reset.
- `a_ack`/`b_ack` are forced to 0 while `rstn` = 0.
- **Latency:** request accepted at edge N → `s_en` high in cycle N+1 → `s_oen` after the `sincos` latency L → `x_en` high one cycle after `s_oen`. Total is L+2 cycles.
- **Throughput:** one grant per cycle, sustained when `DEPTH ≥ L+1`.
- **Reset mid-operation:** all state clears immediately. `sincos` shares `rstn`, so no stale results return after reset.

## Configuration
- Macro `SINCOS_ARB_FIXED_PRIO_EN`.
- **Defined:** A always wins when both requesters are active. `last` is not implemented. B can starve; this is acceptable because Park runs at most once per PWM cycle.
- **Undefined (default):** round-robin as described above.

## Test plan
- **Single A request:** `a_theta`=0 → exactly one `a_en` pulse at L+2 cycles with `a_sin`=0, `a_cos`=16384; `b_en` stays 0; `busy` returns to 0.
- **Simultaneous A and B:** `a_theta`=1024 and `b_theta`=2048 in the same cycle → A acked first, B the next cycle. Expect A: sin=16384, cos=0; then B: sin=0, cos=−16384, one cycle later.
- **Both held for 8 cycles:**
  - Round-robin: grants alternate A,B,A,B; each side gets 4 acks; results return in order with the correct tags.
  - With `SINCOS_ARB_FIXED_PRIO_EN`: A gets all grants while held.
- **Full FIFO:** `DEPTH`=2 and a stubbed `sincos` with L=4, both requesters continuously active → ack is deasserted while `cnt`=2 with no pop. A grant coincides with each `s_oen` pop. No results are lost or duplicated.
- **Spurious result:** drive `s_oen` with the FIFO empty → `err`=1 and sticky; no `x_en` pulse; reset clears `err`.
- **Reset mid-flight:** 3 requests outstanding, pulse `rstn` low → all outputs return to reset values immediately; after release, a new request completes normally.
